// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron-layer input path.
package nn_pkg;
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } isr_state_t;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_INPUTS = 16;
endpackage

// File: rtl/input_shift_register_if.sv
// Upstream word handshake plus the neuron-side output bundle of the input stage.
interface input_shift_register_if
    import nn_pkg::*;
#(
    parameter int dataWidth    = DATA_WIDTH,
    parameter int counterWidth = $clog2(NUM_INPUTS)
);
    logic [dataWidth-1:0]    inData;
    logic                    inValid;
    logic                    inReady;
    logic [dataWidth-1:0]    outData;
    logic                    outValid;
    logic                    outReady;
    logic [counterWidth-1:0] outIndex;
    logic                    outLast;

    modport slave (
        input  inData, inValid, outReady,
        output inReady, outData, outValid, outIndex, outLast
    );

    modport master (
        output inData, inValid, outReady,
        input  inReady, outData, outValid, outIndex, outLast
    );
endinterface

// File: rtl/input_shift_register_index_counter.sv
// Mod-modulus position counter reused by the fill and drain phases.
module isr_index_counter #(
    parameter int modulus = 16,
    parameter int width   = $clog2(modulus)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [width-1:0] count,
    output logic             terminal
);
    assign terminal = (count == width'(modulus - 1));

    // clear wins over enable so an aborted handshake never advances the index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/input_shift_register.sv
// Single-buffer serial-to-neuron input stage: fills numInputs words, then drains them in order.
//   state | meaning
//   FILL  | accepting upstream words into the tail of the array
//   DRAIN | presenting the head word to the neurons, one per handshake
module input_shift_register
    import nn_pkg::*;
#(
    parameter int numInputs    = NUM_INPUTS,
    parameter int dataWidth    = DATA_WIDTH,
    parameter int counterWidth = $clog2(numInputs)
) (
    input logic                    clk,
    input logic                    reset,
    input logic                    flush,
    input_shift_register_if.slave  bus
);
    isr_state_t              state;
    isr_state_t              stateNext;
    logic [dataWidth-1:0]    storage [numInputs];
    logic [counterWidth-1:0] count;
    logic                    terminal;
    logic                    inAccept;
    logic                    outAccept;
    logic                    shiftEn;

    isr_index_counter #(
        .modulus (numInputs),
        .width   (counterWidth)
    ) indexCounter (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .enable   (shiftEn),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    // inReady is gated by reset so it is low for the whole reset window
    always_comb begin
        stateNext     = state;
        inAccept      = 1'b0;
        outAccept     = 1'b0;
        bus.inReady   = 1'b0;
        bus.outValid  = 1'b0;
        bus.outData   = '0;
        bus.outIndex  = '0;
        bus.outLast   = 1'b0;
        case (state)
            FILL: begin
                bus.inReady = reset;
                inAccept    = bus.inValid && reset;
                if (inAccept && terminal) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                bus.outValid = 1'b1;
                bus.outData  = storage[0];
                bus.outIndex = count;
                bus.outLast  = terminal;
                outAccept    = bus.outReady;
                if (outAccept && terminal) begin
                    stateNext = FILL;
                end
            end
            default: stateNext = FILL;
        endcase
        if (flush) begin
            stateNext = FILL;
        end
    end

    assign shiftEn = inAccept || outAccept;

    // Both phases shift toward the head; a flush discards the word of that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < numInputs; i++) begin
                storage[i] <= '0;
            end
        end else if (shiftEn && !flush) begin
            for (int i = 0; i < numInputs - 1; i++) begin
                storage[i] <= storage[i+1];
            end
            storage[numInputs-1] <= inAccept ? bus.inData : '0;
        end
    end
endmodule

// File: tb/tb_input_shift_register.sv
// Self-checking bench for input_shift_register: queue-based reference model plus directed and random traffic.
module tb_input_shift_register;
    localparam int N  = 16;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    input_shift_register_if #(.dataWidth(W), .counterWidth(CW)) bus ();

    input_shift_register #(
        .numInputs    (N),
        .dataWidth    (W),
        .counterWidth (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words collect in a queue until N arrive, then are handed out in order.
    bit             mDrain = 1'b0;
    logic [W-1:0]   mFill[$];
    logic [W-1:0]   mOut[$];
    int             mIdx = 0;

    logic [W-1:0]   outLog[$];
    int             lastCount = 0;

    always @(negedge clk) begin
        logic         eReady, eValid, eLast;
        logic [W-1:0] eData;
        int           eIndex;
        eReady = 1'b0; eValid = 1'b0; eLast = 1'b0; eData = '0; eIndex = 0;
        if (reset === 1'b1) begin
            if (!mDrain) begin
                eReady = 1'b1;
            end else begin
                eValid = 1'b1;
                eData  = mOut[0];
                eIndex = mIdx;
                eLast  = (mIdx == N - 1);
            end
        end
        check("inReady",  32'(bus.inReady),  32'(eReady));
        check("outValid", 32'(bus.outValid), 32'(eValid));
        check("outData",  32'(bus.outData),  32'(eData));
        check("outIndex", 32'(bus.outIndex), 32'(eIndex));
        check("outLast",  32'(bus.outLast),  32'(eLast));

        if (reset === 1'b1 && !flush && bus.outValid && bus.outReady) begin
            outLog.push_back(bus.outData);
            if (bus.outLast) lastCount++;
        end

        if (reset !== 1'b1) begin
            mDrain = 1'b0; mFill.delete(); mOut.delete(); mIdx = 0;
        end else if (flush) begin
            mDrain = 1'b0; mFill.delete(); mOut.delete(); mIdx = 0;
        end else if (!mDrain) begin
            if (bus.inValid) begin
                mFill.push_back(bus.inData);
                if (mFill.size() == N) begin
                    mOut = mFill;
                    mFill.delete();
                    mDrain = 1'b1;
                    mIdx = 0;
                end
            end
        end else if (bus.outReady) begin
            void'(mOut.pop_front());
            mIdx++;
            if (mIdx == N) begin
                mDrain = 1'b0;
                mIdx = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        outLog.delete();
        lastCount = 0;
    endtask

    task automatic fillWords(input logic [W-1:0] base, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                bus.inValid = 1'b0;
                bus.inData  = W'($urandom);
                step();
            end
            bus.inValid = 1'b1;
            bus.inData  = base + W'(i);
            step();
        end
        bus.inValid = 1'b0;
    endtask

    task automatic drainWords(input int stallIdx, input int stallLen, input logic [W-1:0] stallData,
                              input logic [W-1:0] junk, input bit junkValid, output int cycles);
        int stalled = 0;
        bit done = 1'b0;
        cycles = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.inValid  = junkValid;
            bus.inData   = junk;
            bus.outReady = 1'b1;
            if (bus.outValid && int'(bus.outIndex) == stallIdx && stalled < stallLen) begin
                bus.outReady = 1'b0;
                stalled++;
                check("stall_data",  32'(bus.outData),  32'(stallData));
                check("stall_index", 32'(bus.outIndex), 32'(stallIdx));
            end
            if (bus.outValid) cycles++;
            done = bus.outValid && bus.outLast && bus.outReady;
            step();
        end
        if (!done) check("drain_timeout", 32'(0), 32'(1));
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
    endtask

    task automatic checkLog(input string name, input logic [W-1:0] base);
        check({name, "_size"}, 32'(outLog.size()), 32'(N));
        for (int i = 0; i < N && i < outLog.size(); i++) begin
            check({name, "_word"}, 32'(outLog[i]), 32'(base + W'(i)));
        end
        check({name, "_lastCount"}, 32'(lastCount), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int cyc;
        reset = 1'b0; flush = 1'b0;
        bus.inData = '0; bus.inValid = 1'b0; bus.outReady = 1'b1;
        repeat (3) step();
        check("reset_inReady", 32'(bus.inReady), 32'(0));
        reset = 1'b1;
        #1;
        check("release_inReady", 32'(bus.inReady), 32'(1));
        step();

        // 1: straight fill and drain, inValid held high into the drain
        clearLog();
        fillWords(8'h01, 1'b0);
        check("t1_first_valid", 32'(bus.outValid), 32'(1));
        check("t1_first_data",  32'(bus.outData),  32'(8'h01));
        drainWords(-1, 0, 8'h00, 8'h11, 1'b1, cyc);
        check("t1_drain_cycles", 32'(cyc), 32'(16));
        check("t1_inReady_after", 32'(bus.inReady), 32'(1));
        checkLog("t1", 8'h01);

        // 2: fill with alternating inValid gaps
        clearLog();
        fillWords(8'h01, 1'b1);
        drainWords(-1, 0, 8'h00, 8'h00, 1'b0, cyc);
        checkLog("t2", 8'h01);

        // 3: three-cycle stall at index 5
        clearLog();
        fillWords(8'h01, 1'b0);
        drainWords(5, 3, 8'h06, 8'h00, 1'b0, cyc);
        check("t3_drain_cycles", 32'(cyc), 32'(19));
        checkLog("t3", 8'h01);

        // 4: 0xFF offered throughout drain must never be captured
        clearLog();
        fillWords(8'h01, 1'b0);
        drainWords(-1, 0, 8'h00, 8'hFF, 1'b1, cyc);
        checkLog("t4", 8'h01);
        clearLog();
        fillWords(8'h40, 1'b0);
        check("t4_next_index", 32'(bus.outIndex), 32'(0));
        check("t4_next_data",  32'(bus.outData),  32'(8'h40));
        drainWords(-1, 0, 8'h00, 8'h00, 1'b0, cyc);
        checkLog("t4b", 8'h40);

        // 5: reset mid-drain at index 8
        fillWords(8'h01, 1'b0);
        bus.outReady = 1'b1;
        for (int c = 0; c < 40 && !(bus.outValid && bus.outIndex == 4'd8); c++) step();
        check("t5_reached_8", 32'(bus.outIndex), 32'(8));
        reset = 1'b0;
        #1;
        check("t5_rst_outValid", 32'(bus.outValid), 32'(0));
        check("t5_rst_inReady",  32'(bus.inReady),  32'(0));
        check("t5_rst_outData",  32'(bus.outData),  32'(0));
        step(); step();
        reset = 1'b1;
        #1;
        check("t5_post_inReady", 32'(bus.inReady), 32'(1));
        step();
        clearLog();
        fillWords(8'hA0, 1'b0);
        drainWords(-1, 0, 8'h00, 8'h00, 1'b0, cyc);
        checkLog("t5", 8'hA0);

        // 6: flush after 7 accepts, flush beats a concurrent accept
        clearLog();
        for (int i = 0; i < 7; i++) begin
            bus.inValid = 1'b1;
            bus.inData  = 8'h50 + W'(i);
            step();
        end
        flush = 1'b1; bus.inValid = 1'b1; bus.inData = 8'h77;
        step();
        flush = 1'b0; bus.inValid = 1'b0;
        fillWords(8'h20, 1'b0);
        drainWords(-1, 0, 8'h00, 8'h00, 1'b0, cyc);
        checkLog("t6", 8'h20);

        // 7: random traffic, flushes and resets against the model
        for (int c = 0; c < 1500; c++) begin
            bus.inValid  = 1'($urandom_range(0, 1));
            bus.inData   = W'($urandom);
            bus.outReady = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 60) == 0);
            reset        = ($urandom_range(0, 200) != 0);
            step();
        end
        reset = 1'b1; flush = 1'b0; bus.inValid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_shift_register.md
Name: input_shift_register

Overview:
Single-buffer serial-to-neuron input stage for one layer.
- Accepts numInputs activation words from upstream (pixel source or previous layer) via a valid/ready handshake.
- Once full, streams them one word per cycle, in arrival order, to the neuron array. outValid drives the neurons' neuronValid input.
- outIndex drives the neurons' weight-address / input-counter logic.

Parameters:
numInputs, 16, number of activation words per inference (≥2)
dataWidth, 8, activation word width in bits
counterWidth, $clog2(numInputs), width of fill/drain index

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort: return to FILL, count cleared
inData  input  dataWidth  upstream activation word
inValid  input  1  inData valid
inReady  output  1  block can accept a word this cycle
outData  output  dataWidth  current head word to neurons
outValid  output  1  outData valid (neuronValid)
outReady  input  1  neurons consume head word this cycle
outIndex  output  counterWidth  position (0..numInputs-1) of outData
outLast  output  1  high with the final word of the drain (outIndex==numInputs-1)

Behaviour:
- Reset asserted (reset==0):
  - state=FILL, count=0.
  - inReady=0, outValid=0, outLast=0, outIndex=0, outData=0.
  - Storage registers cleared.
  - inReady is forced low while reset is asserted. It becomes high in the first cycle after reset deasserts.
- State FILL:
  - inReady=1, outValid=0.
  - Accept = inValid&&inReady. On accept, shift inData into the tail; the first accepted word reaches the head after numInputs accepts. count++.
  - Gaps in inValid are allowed. Contents and count hold.
  - On the accept with count==numInputs-1: count←0, state←DRAIN.
- State DRAIN:
  - inReady=0. inValid is ignored and no data is captured.
  - outValid=1, outData=head word, outIndex=count, outLast=(count==numInputs-1).
  - Latency: the final fill accept in cycle N gives outValid=1 with word 0 in cycle N+1.
  - On outValid&&outReady: shift storage toward the head, count++.
  - outReady low: all outputs hold stable, with no shift and no count change.
  - On the handshake with count==numInputs-1: count←0, state←FILL. inReady=1 in the next cycle.
  - Fill and drain never overlap. The minimum period is 2·numInputs cycles.
- outData, outIndex and outLast are valid only while outValid=1. In FILL they are driven to 0.
- flush=1 (synchronous):
  - Next state is FILL with count=0, in either state. Storage is not cleared.
  - flush has priority over any handshake in the same cycle; that word is discarded.
- Reset mid-operation: immediate return to reset values. No partial output follows.
- count wraps only via the explicit terminal transitions; it never exceeds numInputs-1.

Decomposition:
- Shared package nn_pkg holds:
  - state enum isr_state_t {FILL, DRAIN}
  - default DATA_WIDTH=8
  - default NUM_INPUTS=16
- One natural sub-module is isr_index_counter.
  - Mod-numInputs counter with enable, synchronous clear (flush) and async active-low reset.
  - Outputs count and terminal flag.
  - Shared by the fill and drain phases.
- Storage is a dataWidth×numInputs register array held in the top level.

Test Plan:
- Fill 0x01..0x10 with inValid=1 and outReady=1 held high → outValid high 16 consecutive cycles with outData 0x01..0x10 and outIndex 0..15; outLast only at 0x10; inReady=0 throughout drain, then 1 again.
- Fill with inValid toggling every other cycle → drained sequence still 0x01..0x10 in order; count advances only on accepts.
- During drain, hold outReady=0 for 3 cycles at outIndex=5 → outData=0x06 and outIndex=5 stable for 3 cycles, then the sequence resumes at 0x07.
- Drive inValid=1 with inData=0xFF throughout drain → 0xFF never appears in the output; next fill starts at outIndex 0.
- Assert reset low at outIndex=8 → outValid=0 and inReady=0 immediately; after release, inReady=1 and a fresh fill of 0xA0..0xAF drains correctly.
- Pulse flush after 7 fill accepts, then fill 0x20..0x2F → output is exactly 0x20..0x2F; outLast asserts once.
